// File: rtl/prim_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package prim_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prim_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N.
module prim_arbiter_rr_pick
    import prim_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 8,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    localparam logic [IdxW:0] NumPorts = (IdxW + 1)'(N);

    logic [N-1:0]    rot;
    logic [IdxW-1:0] off;
    logic [IdxW:0]   sum;

    // Rotating the doubled vector puts ptr_i at bit 0, so the lowest set bit is the winner's offset.
    always_comb begin
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IdxW'(i);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NumPorts) sum = sum - NumPorts;
        valid_o = |req_i;
        idx_o   = valid_o ? sum[IdxW-1:0] : '0;
    end

endmodule

// File: rtl/prim_arbiter_rr_pkt.sv
// N:1 round-robin arbiter that holds the grant until the winner's last beat is accepted.
// Optional output forward register enabled by defining PRIM_ARB_RR_OUT_REG_EN.
module prim_arbiter_rr_pkt
    import prim_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 8,
    parameter  int unsigned DW   = 32,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [DW-1:0]   data_i [N],
    input  logic [N-1:0]    last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    output logic            last_o,
    input  logic            ready_i,
    output logic            locked_o
);

    if (N < 2) begin : g_bad_n
        $error("prim_arbiter_rr_pkt: N must be at least 2");
    end

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic [IdxW-1:0] sel_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            acc_rdy;
    logic            fire;

    prim_arbiter_rr_pick #(.N(N)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // While locked, every other requester is masked, even higher-priority ones.
    always_comb begin
        if (state_q == ARB_LOCKED) begin
            sel_idx   = lock_idx_q;
            sel_valid = req_i[lock_idx_q];
        end else begin
            sel_idx   = pick_idx;
            sel_valid = pick_valid;
        end
        sel_data = sel_valid ? data_i[sel_idx] : '0;
        sel_last = sel_valid & last_i[sel_idx];
        fire     = sel_valid & acc_rdy;
        gnt_o    = '0;
        if (fire) gnt_o[sel_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (fire) begin
            if (sel_last) begin
                state_d = ARB_IDLE;
                ptr_d   = (sel_idx == IdxW'(N - 1)) ? '0 : sel_idx + 1'b1;
            end else if (state_q == ARB_IDLE) begin
                state_d    = ARB_LOCKED;
                lock_idx_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign locked_o = (state_q == ARB_LOCKED);

`ifdef PRIM_ARB_RR_OUT_REG_EN
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [IdxW-1:0] out_idx_q;
    logic            out_last_q;

    // A new beat may load in the same cycle the held one drains, keeping full throughput.
    assign acc_rdy = !out_valid_q || ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
        end else if (ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            out_data_q <= sel_data;
            out_idx_q  <= sel_idx;
            out_last_q <= sel_last;
        end
    end

    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
    assign idx_o   = out_idx_q;
    assign last_o  = out_last_q;
`else
    assign acc_rdy = ready_i;
    assign valid_o = sel_valid;
    assign data_o  = sel_data;
    assign idx_o   = sel_idx;
    assign last_o  = sel_last;
`endif

endmodule

// File: tb/tb_prim_arbiter_rr_pkt.sv
// Randomized scoreboard bench for prim_arbiter_rr_pkt against a behavioural packet-arbitration model.
module tb_prim_arbiter_rr_pkt;

    localparam int N    = 8;
    localparam int DW   = 32;
    localparam int IdxW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [DW-1:0]   data_i [N];
    logic [N-1:0]    last_i;
    logic [N-1:0]    gnt_o;
    logic [IdxW-1:0] idx_o;
    logic            valid_o;
    logic [DW-1:0]   data_o;
    logic            last_o;
    logic            ready_i;
    logic            locked_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t exp_q[$];

    // Requester-side pending beats and the arbiter's abstract state.
    bit            pend  [N];
    logic [DW-1:0] pdata [N];
    bit            plast [N];
    bit            m_locked;
    int            m_lock;
    int            m_ptr;
    bit            m_full;
    int            resets_done = 0;

    prim_arbiter_rr_pkt #(.N(N), .DW(DW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .gnt_o    (gnt_o),
        .idx_o    (idx_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .ready_i  (ready_i),
        .locked_o (locked_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_lock   = 0;
        m_ptr    = 0;
        m_full   = 0;
        for (int k = 0; k < N; k++) pend[k] = 0;
        exp_q.delete();
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_i[k]  = pend[k];
            data_i[k] = pend[k] ? pdata[k] : $urandom;
            last_i[k] = pend[k] ? plast[k] : 1'($urandom);
        end
    endtask

    task automatic mid_reset();
        rst     = 1'b1;
        ready_i = 1'b0;
        #1;
        check("reset_mid_locked", 64'(locked_o), 64'd0);
        check("reset_mid_gnt", 64'(gnt_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        resets_done++;
        pend[0] = 1; pdata[0] = $urandom; plast[0] = 1;
        pend[5] = 1; pdata[5] = $urandom; plast[5] = 1;
    endtask

    task automatic cycle(input bit gen, input int cyc);
        int  sel;
        bit  acc;
        bit  accept;
        bit  exp_valid;
        @(negedge clk);
        if (gen && cyc >= 300 && resets_done < 4 && m_locked && $urandom_range(0, 19) == 0)
            mid_reset();
        for (int k = 0; k < N; k++) begin
            if (gen && !pend[k] && $urandom_range(0, 99) < 25) begin
                pend[k]  = 1;
                pdata[k] = $urandom;
                plast[k] = ($urandom_range(0, 2) == 0);
            end
        end
        ready_i = gen ? ($urandom_range(0, 99) < 70) : 1'b1;
        drive();
        #1;
        sel = -1;
        if (m_locked) begin
            if (pend[m_lock]) sel = m_lock;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (sel < 0 && pend[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
            end
        end
`ifdef PRIM_ARB_RR_OUT_REG_EN
        acc       = !m_full || ready_i;
        exp_valid = m_full;
`else
        acc       = ready_i;
        exp_valid = (sel >= 0);
`endif
        accept = (sel >= 0) && acc;
        check("valid_o", 64'(valid_o), 64'(exp_valid));
        check("gnt_o", 64'(gnt_o), accept ? (64'd1 << sel) : 64'd0);
        check("locked_o", 64'(locked_o), 64'(m_locked));
        if (accept) begin
            exp_q.push_back('{idx: sel, data: pdata[sel], last: plast[sel]});
            if (plast[sel]) begin
                m_locked = 0;
                m_ptr    = (sel + 1) % N;
            end else if (!m_locked) begin
                m_locked = 1;
                m_lock   = sel;
            end
            pend[sel] = 0;
        end
`ifdef PRIM_ARB_RR_OUT_REG_EN
        m_full = accept || (m_full && !ready_i);
`endif
    endtask

    // Monitor: every beat the sink takes must be the oldest one the model predicted.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sink_beat: unexpected beat idx %0d data %0h, expected none", idx_o, data_o);
                end else begin
                    b = exp_q.pop_front();
                    check("sink_idx", 64'(idx_o), 64'(b.idx));
                    check("sink_data", 64'(data_o), 64'(b.data));
                    check("sink_last", 64'(last_o), 64'(b.last));
`ifndef PRIM_ARB_RR_OUT_REG_EN
                    check("sink_data_mux", 64'(data_o), 64'(data_i[idx_o]));
`endif
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        ready_i = 1'b0;
        req_i   = '1;
        last_i  = '1;
        for (int k = 0; k < N; k++) data_i[k] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_gnt", 64'(gnt_o), 64'd0);
        check("reset_locked", 64'(locked_o), 64'd0);
`ifdef PRIM_ARB_RR_OUT_REG_EN
        check("reset_valid", 64'(valid_o), 64'd0);
`endif
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1;
            pdata[k] = $urandom;
            plast[k] = 1;
        end
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) cycle(c < 3800, c);
        @(negedge clk);
        #3;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
